sdram_port_arbiter: RTL and testbench

//  Shares the single byte-wide sdram port between two requesters.
//   - Port 0: the ROM/cartridge download writer (data_io side). Highest priority.
//   - Port 1: the CPU external-RAM / ROM-pack path (Pla1 side).

---
 rtl/sdram_port_arbiter.sv | 150 +++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter
//
// Lets two requesters share the single byte-wide sdram port, one complete access per slot.
//   Port 0 is the ROM/cartridge download writer. It has the highest priority.
//   Port 1 is the CPU external-RAM / ROM-pack path.
// Each access holds mem_addr, mem_din, mem_we and mem_oe stable for CYCLE_LEN clocks.
// The winner then gets a one-cycle ack. Port 1 read data is captured into p1_dout.
//
// Ports
//   clk, reset           ram clock; asynchronous active-high reset
//   p0_req/addr/din      download write request (level), held until p0_ack
//   p0_ack               one-cycle pulse when the p0 access completes
//   p1_req/we/addr/din   CPU request (level); p1_we=1 write, 0 read
//   p1_dout              last p1 read data, valid from p1_ack onward
//   p1_ack               one-cycle pulse when the p1 access completes
//   mem_addr/din/we/oe   to the sdram controller
//   mem_dout             from the sdram controller
//   busy                 high while an access is in flight (ISSUE or DONE)
//
// Optional feature: define SDRAM_ARB_ROMPACK_PROTECT_EN to turn p1 writes
// into the cartridge area (p1_addr[15:14]==2'b11) into no-op slots that still ack.

module sdram_port_arbiter #(
    parameter int ADDR_W     = 25,
    parameter int DATA_W     = 8,
    parameter int CYCLE_LEN  = 8,
    parameter int MAX_P0_RUN = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p0_req,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_din,
    output logic              p0_ack,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_din,
    output logic [DATA_W-1:0] p1_dout,
    output logic              p1_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_we,
    output logic              mem_oe,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

    localparam logic [7:0] LAST_CNT  = 8'(CYCLE_LEN - 1);
    localparam logic [3:0] RUN_LIMIT = 4'(MAX_P0_RUN);

    state_t     state;
    logic [7:0] cnt;
    logic [3:0] run;
    logic       grant_p1;
    logic       p1_read;
    logic       pick_p1;
    logic       p1_write_blocked;

    // p0 keeps priority until it has been granted MAX_P0_RUN slots in a row while p1 waited.
    assign pick_p1 = p1_req && (!p0_req || run == RUN_LIMIT);

`ifdef SDRAM_ARB_ROMPACK_PROTECT_EN
    // A write into the cartridge window still takes a full slot, but it never strobes we.
    assign p1_write_blocked = (p1_addr[15:14] == 2'b11);
`else
    assign p1_write_blocked = 1'b0;
`endif

    // Runs one access per slot. Requests are sampled only in IDLE, so a requester that
    // still holds req while DONE is being acked cannot get a duplicate grant.
    // Reset drops we/oe at once and abandons any partial slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            run      <= '0;
            grant_p1 <= 1'b0;
            p1_read  <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
            mem_we   <= 1'b0;
            mem_oe   <= 1'b0;
            p0_ack   <= 1'b0;
            p1_ack   <= 1'b0;
            p1_dout  <= '0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    p0_ack <= 1'b0;
                    p1_ack <= 1'b0;
                    if (p0_req || p1_req) begin
                        state    <= ISSUE;
                        cnt      <= '0;
                        busy     <= 1'b1;
                        grant_p1 <= pick_p1;
                        if (pick_p1) begin
                            mem_addr <= p1_addr;
                            mem_din  <= p1_din;
                            mem_we   <= p1_we && !p1_write_blocked;
                            mem_oe   <= !p1_we;
                            p1_read  <= !p1_we;
                            run      <= '0;
                        end else begin
                            mem_addr <= p0_addr;
                            mem_din  <= p0_din;
                            mem_we   <= 1'b1;
                            mem_oe   <= 1'b0;
                            p1_read  <= 1'b0;
                            // The run count only grows while p1 is actually waiting. It
                            // saturates at the limit.
                            if (p1_req && run < RUN_LIMIT) begin
                                run <= run + 4'd1;
                            end
                        end
                    end
                end
                ISSUE: begin
                    cnt <= cnt + 8'd1;
                    if (cnt == LAST_CNT) begin
                        state  <= DONE;
                        mem_we <= 1'b0;
                        mem_oe <= 1'b0;
                        if (p1_read) begin
                            p1_dout <= mem_dout;
                        end
                        if (grant_p1) begin
                            p1_ack <= 1'b1;
                        end else begin
                            p0_ack <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    p0_ack <= 1'b0;
                    p1_ack <= 1'b0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter
//
// Randomized and directed bench for sdram_port_arbiter.
// The reference model tracks each slot as "edges since grant" and the arbitration rules.
// From those it derives every expected mem_*, ack, busy and p1_dout value each cycle.

module tb_sdram_port_arbiter;

    localparam int ADDR_W     = 25;
    localparam int DATA_W     = 8;
    localparam int CYCLE_LEN  = 8;
    localparam int MAX_P0_RUN = 4;

    localparam int MANUAL = 0;
    localparam int RANDOM = 1;
    localparam int HOLD   = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              p0_req;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_din;
    logic              p0_ack;
    logic              p1_req;
    logic              p1_we;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_din;
    logic [DATA_W-1:0] p1_dout;
    logic              p1_ack;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic              mem_we;
    logic              mem_oe;
    logic [DATA_W-1:0] mem_dout;
    logic              busy;

    sdram_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CYCLE_LEN(CYCLE_LEN), .MAX_P0_RUN(MAX_P0_RUN)
    ) dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_addr(p0_addr), .p0_din(p0_din), .p0_ack(p0_ack),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_din(p1_din),
        .p1_dout(p1_dout), .p1_ack(p1_ack),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_oe(mem_oe),
        .mem_dout(mem_dout), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    // Reference model state.
    int                age;
    int                run;
    bit                win1;
    bit                acc_we;
    bit                acc_oe;
    bit                is_read;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_din;
    logic [DATA_W-1:0] exp_dout;

    int mode0, mode1, wait0, wait1;
    bit rand_dout;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic modelReset();
        age = -1; run = 0; win1 = 0; acc_we = 0; acc_oe = 0; is_read = 0;
        exp_addr = '0; exp_din = '0; exp_dout = '0;
    endtask

    function automatic bit isProtected(input logic [ADDR_W-1:0] a, input logic we);
`ifdef SDRAM_ARB_ROMPACK_PROTECT_EN
        return we && (a[15:14] == 2'b11);
`else
        return 1'b0;
`endif
    endfunction

    task automatic newP0();
        p0_addr = ADDR_W'($urandom);
        p0_din  = DATA_W'($urandom);
        p0_req  = 1'b1;
    endtask

    task automatic newP1();
        p1_addr = ADDR_W'($urandom);
        if ($urandom_range(0, 1) == 1) p1_addr[15:14] = 2'b11;
        p1_din  = DATA_W'($urandom);
        p1_we   = 1'($urandom_range(0, 1));
        p1_req  = 1'b1;
    endtask

    // One clock: sample inputs, advance the model on the edge, compare, then let the requesters react.
    task automatic applyStimulus();
        bit                r0, r1, we1, want_ack;
        logic [ADDR_W-1:0] a0, a1;
        logic [DATA_W-1:0] d0, d1, dm;
        r0 = p0_req; r1 = p1_req; we1 = p1_we;
        a0 = p0_addr; a1 = p1_addr; d0 = p0_din; d1 = p1_din; dm = mem_dout;
        @(posedge clk);
        #1;
        cyc++;
        if (age < 0) begin
            if (r0 || r1) begin
                win1 = r1 && (!r0 || run == MAX_P0_RUN);
                if (win1) begin
                    run = 0;
                    exp_addr = a1; exp_din = d1;
                    acc_we = we1 && !isProtected(a1, we1);
                    acc_oe = !we1;
                    is_read = !we1;
                end else begin
                    if (r1 && run < MAX_P0_RUN) run++;
                    exp_addr = a0; exp_din = d0;
                    acc_we = 1; acc_oe = 0; is_read = 0;
                end
                age = 0;
            end
        end else begin
            age++;
            if (age == CYCLE_LEN && win1 && is_read) exp_dout = dm;
            if (age == CYCLE_LEN + 1) age = -1;
        end
        want_ack = (age == CYCLE_LEN);
        checkOutput("busy",     32'(busy),     32'(age >= 0));
        checkOutput("mem_we",   32'(mem_we),   32'(age >= 0 && age < CYCLE_LEN && acc_we));
        checkOutput("mem_oe",   32'(mem_oe),   32'(age >= 0 && age < CYCLE_LEN && acc_oe));
        checkOutput("p0_ack",   32'(p0_ack),   32'(want_ack && !win1));
        checkOutput("p1_ack",   32'(p1_ack),   32'(want_ack && win1));
        checkOutput("mem_addr", 32'(mem_addr), 32'(exp_addr));
        checkOutput("mem_din",  32'(mem_din),  32'(exp_din));
        checkOutput("p1_dout",  32'(p1_dout),  32'(exp_dout));

        if (p0_ack) begin
            if (mode0 == HOLD) newP0();
            else begin p0_req = 1'b0; wait0 = $urandom_range(0, 4); end
        end else if (!p0_req && mode0 == RANDOM) begin
            if (wait0 == 0) newP0(); else wait0--;
        end
        if (p1_ack) begin
            if (mode1 == HOLD) newP1();
            else begin p1_req = 1'b0; wait1 = $urandom_range(0, 4); end
        end else if (!p1_req && mode1 == RANDOM) begin
            if (wait1 == 0) newP1(); else wait1--;
        end
        if (rand_dout) mem_dout = DATA_W'($urandom);
    endtask

    task automatic doReset();
        reset = 1'b1;
        p0_req = 1'b0; p1_req = 1'b0;
        mode0 = MANUAL; mode1 = MANUAL;
        modelReset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    int cnt_a, cnt_b, cnt_c, t0, t1;

    initial begin
        reset = 1'b1;
        p0_req = 0; p0_addr = '0; p0_din = '0;
        p1_req = 0; p1_we = 0; p1_addr = '0; p1_din = '0;
        mem_dout = '0; rand_dout = 1;
        mode0 = MANUAL; mode1 = MANUAL; wait0 = 0; wait1 = 0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_busy",  32'(busy),     32'(0));
        checkOutput("rst_we",    32'(mem_we),   32'(0));
        checkOutput("rst_oe",    32'(mem_oe),   32'(0));
        checkOutput("rst_acks",  32'({p0_ack, p1_ack}), 32'(0));
        checkOutput("rst_addr",  32'(mem_addr), 32'(0));
        checkOutput("rst_dout",  32'(p1_dout),  32'(0));
        reset = 1'b0;

        // p1 read of 0x123 returns 0xA5 after an 8-clock oe strobe.
        rand_dout = 0; mem_dout = 8'hA5;
        p1_req = 1; p1_we = 0; p1_addr = 25'h0000123;
        cnt_a = 0;
        repeat (8) begin applyStimulus(); cnt_a += 32'(mem_oe); end
        applyStimulus();
        checkOutput("t1_ack_at_8", 32'(p1_ack), 32'(1));
        cnt_a += 32'(mem_oe);
        checkOutput("t1_oe_clocks", 32'(cnt_a), 32'(8));
        applyStimulus();
        checkOutput("t1_dout", 32'(p1_dout), 32'h0A5);
        rand_dout = 1;

        // p0 write: 8-clock we strobe, one p0 ack, no p1 ack.
        p0_req = 1; p0_addr = 25'h0003000; p0_din = 8'h3C;
        cnt_a = 0; cnt_b = 0; cnt_c = 0;
        repeat (10) begin
            applyStimulus();
            cnt_a += 32'(mem_we); cnt_b += 32'(p0_ack); cnt_c += 32'(p1_ack);
        end
        checkOutput("t2_we_clocks", 32'(cnt_a), 32'(8));
        checkOutput("t2_p0_acks",   32'(cnt_b), 32'(1));
        checkOutput("t2_p1_acks",   32'(cnt_c), 32'(0));

        // Simultaneous requests: p0 first, p1 acked 10 clocks later.
        p0_req = 1; p0_addr = 25'h0000500; p0_din = 8'h11;
        p1_req = 1; p1_we = 1; p1_addr = 25'h0000055; p1_din = 8'h22;
        t0 = -1; t1 = -1;
        for (int i = 1; i <= 30; i++) begin
            applyStimulus();
            if (p0_ack && t0 < 0) t0 = i;
            if (p1_ack && t1 < 0) t1 = i;
        end
        checkOutput("t3_p0_ack_step", 32'(t0), 32'(9));
        checkOutput("t3_spacing",     32'(t1 - t0), 32'(10));

        // Both held: four p0 slots, then one p1 slot, repeating.
        doReset();
        mode0 = HOLD; mode1 = HOLD;
        newP0(); newP1();
        cnt_a = 0; cnt_b = 0;
        repeat (100) begin
            applyStimulus();
            cnt_a += 32'(p0_ack); cnt_b += 32'(p1_ack);
        end
        mode0 = MANUAL; mode1 = MANUAL; p0_req = 0; p1_req = 0;
        checkOutput("t4_p0_acks", 32'(cnt_a), 32'(8));
        checkOutput("t4_p1_acks", 32'(cnt_b), 32'(2));

        // Reset three clocks into a p1 write abandons it immediately.
        applyStimulus();
        p1_req = 1; p1_we = 1; p1_addr = 25'h0000200; p1_din = 8'h77;
        repeat (4) applyStimulus();
        reset = 1'b1;
        #1;
        checkOutput("t5_we_async",   32'(mem_we), 32'(0));
        checkOutput("t5_busy_async", 32'(busy),   32'(0));
        p1_req = 0;
        modelReset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        cnt_a = 0;
        repeat (12) begin applyStimulus(); cnt_a += 32'(p0_ack) + 32'(p1_ack); end
        checkOutput("t5_no_ack", 32'(cnt_a), 32'(0));
        p1_req = 1; p1_we = 0; p1_addr = 25'h0000040;
        cnt_a = 0;
        repeat (12) begin applyStimulus(); cnt_a += 32'(p1_ack); end
        checkOutput("t5_followup_ack", 32'(cnt_a), 32'(1));

`ifdef SDRAM_ARB_ROMPACK_PROTECT_EN
        // Cartridge-area writes are swallowed. Writes just below that area go through.
        p1_req = 1; p1_we = 1; p1_addr = 25'h000C010; p1_din = 8'h99;
        cnt_a = 0; cnt_b = 0;
        repeat (12) begin applyStimulus(); cnt_a += 32'(mem_we); cnt_b += 32'(p1_ack); end
        checkOutput("t6_prot_we",  32'(cnt_a), 32'(0));
        checkOutput("t6_prot_ack", 32'(cnt_b), 32'(1));
        p1_req = 1; p1_we = 1; p1_addr = 25'h0008010;
        cnt_a = 0;
        repeat (12) begin applyStimulus(); cnt_a += 32'(mem_we); end
        checkOutput("t6_open_we", 32'(cnt_a), 32'(8));
`endif

        // Random traffic on both ports.
        mode0 = RANDOM; mode1 = RANDOM; wait0 = 0; wait1 = 2;
        repeat (2000) applyStimulus();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
